rd_fram_pingpong_buf: RTL and testbench

//  Multi-bank line buffer between the DDR read path and the video output path, single clock.

---
 rtl/rd_fram_pingpong_buf_pkg.sv | 33 +++
 rtl/rd_fram_pingpong_buf_sdpram.sv | 29 ++
 rtl/rd_fram_pingpong_buf.sv | 217 +++++++++++++++++++++
 tb/tb_rd_fram_pingpong_buf.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rd_fram_pingpong_buf_pkg.sv
// Shared definitions for the rd_fram line buffer.
// Contents:
//   bank_state_e  per-bank lifecycle (FREE=0, FILLING=1, FULL=2, DRAINING=3)
//   clog2         ceiling log2, usable in constant expressions
//   clog2_min1    clog2 but never below 1, for index fields that must exist
//   is_pow2       parameter-legality helper
package rd_fram_pingpong_buf_pkg;

    typedef enum logic [1:0] {
        BANK_FREE     = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic int clog2_min1(input int value);
        return (value > 1) ? clog2(value) : 1;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/rd_fram_pingpong_buf_sdpram.sv
// Simple dual-port RAM, single clock, registered read (1-cycle latency,
// no extra output register). Read-during-write to the same address is
// never exercised by the buffer, so its result is left unspecified.
// Ports:
//   clk            clock
//   we/waddr/wdata write port
//   re/raddr       read request; rdata valid the cycle after re
//   rdata          read data
module rd_fram_pingpong_buf_sdpram #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [1 << ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/rd_fram_pingpong_buf.sv
// Multi-bank line buffer between the DDR read path and the video output.
// Wide words are written bank by bank; each completed bank is drained as a
// valid/ready stream of narrow beats, least-significant sub-word first.
//
// state         | meaning
// BANK_FREE     | empty, may be written
// BANK_FILLING  | partially written
// BANK_FULL     | all LINE_WORDS written, no read issued yet
// BANK_DRAINING | reads issued; returns to FREE on the rd_last handshake
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   frame_sync          synchronous flush of all banks and pointers
//   wr_data/wr_en       write word / strobe, accepted when wr_ready
//   wr_ready            current write bank is FREE or FILLING
//   rd_data/rd_valid    output beat stream, rd_ready from consumer
//   rd_last             last beat of a bank
//   buf_req             1-cycle pulse after a bank returns to FREE
//   free_banks          number of FREE banks
//   ovf_err             sticky: write attempted while not ready
module rd_fram_pingpong_buf
    import rd_fram_pingpong_buf_pkg::*;
#(
    parameter int WR_DATA_WIDTH = 128,
    parameter int RD_DATA_WIDTH = 32,
    parameter int RATIO         = 4,
    parameter int LINE_WORDS    = 256,
    parameter int NUM_BANKS     = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             frame_sync,
    input  logic [WR_DATA_WIDTH-1:0]         wr_data,
    input  logic                             wr_en,
    output logic                             wr_ready,
    output logic [RD_DATA_WIDTH-1:0]         rd_data,
    output logic                             rd_valid,
    input  logic                             rd_ready,
    output logic                             rd_last,
    output logic                             buf_req,
    output logic [clog2(NUM_BANKS+1)-1:0]    free_banks,
    output logic                             ovf_err
);

    localparam int BW         = clog2_min1(NUM_BANKS);
    localparam int AW         = clog2(LINE_WORDS);
    localparam int SW         = clog2_min1(RATIO);
    localparam int FW         = clog2(NUM_BANKS + 1);
    localparam int BANK_SLOTS = 1 << BW;

    localparam logic [BW-1:0] LAST_BANK = BW'(NUM_BANKS - 1);
    localparam logic [AW-1:0] LAST_WORD = AW'(LINE_WORDS - 1);
    localparam logic [SW-1:0] LAST_SUB  = SW'(RATIO - 1);

    if (!is_pow2(RATIO) || RATIO > 16 || WR_DATA_WIDTH != RATIO * RD_DATA_WIDTH) begin : g_bad_ratio
        $error("rd_fram_pingpong_buf: illegal RATIO / data width combination");
    end
    if (!is_pow2(LINE_WORDS) || LINE_WORDS < 2) begin : g_bad_line
        $error("rd_fram_pingpong_buf: LINE_WORDS must be a power of 2 >= 2");
    end
    if (NUM_BANKS < 1 || NUM_BANKS > 8) begin : g_bad_banks
        $error("rd_fram_pingpong_buf: NUM_BANKS must be 1..8");
    end

    // Array padded to a power of two so a BW-bit index is always in range;
    // padding slots stay FREE and are excluded from free_banks.
    bank_state_e bank_st  [BANK_SLOTS];
    bank_state_e bank_nxt [BANK_SLOTS];

    logic [BW-1:0] wb;       // write bank
    logic [BW-1:0] rb;       // bank released by the next rd_last
    logic [BW-1:0] ib;       // bank receiving RAM read issues (runs ahead of rb)
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;

    logic wr_fire;
    logic rd_fire;
    logic pop_word;
    logic release_bank;
    logic issue;
    logic issue_ok;
    logic [2:0] occ;

    logic                     rd_pend;
    logic                     rd_pend_last;
    logic [WR_DATA_WIDTH-1:0] ram_rd_data;

    // Two-entry wide-word prefetch so one word can drain while the next
    // is both in the RAM pipeline and waiting, giving 1 beat/cycle at RATIO=1.
    logic [WR_DATA_WIDTH-1:0] pf_data [2];
    logic                     pf_last [2];
    logic                     pf_rp;
    logic                     pf_wp;
    logic [1:0]               pf_cnt;
    logic [SW-1:0]            sub;

    function automatic logic [BW-1:0] bank_inc(input logic [BW-1:0] b);
        return (b == LAST_BANK) ? '0 : b + 1'b1;
    endfunction

    assign wr_ready     = (bank_st[wb] == BANK_FREE) || (bank_st[wb] == BANK_FILLING);
    assign wr_fire      = wr_en && wr_ready && !frame_sync;
    assign rd_valid     = (pf_cnt != 2'd0);
    assign rd_last      = rd_valid && pf_last[pf_rp] && (sub == LAST_SUB);
    assign rd_fire      = rd_valid && rd_ready && !frame_sync;
    assign pop_word     = rd_fire && (sub == LAST_SUB);
    assign release_bank = rd_fire && rd_last;

    assign issue_ok = (raddr != '0) || (bank_st[ib] == BANK_FULL);
    assign occ      = 3'(pf_cnt) + 3'(rd_pend);
    // A word leaving this cycle frees a slot, so a full pipeline may still issue.
    assign issue    = !frame_sync && issue_ok && ((occ < 3'd2) || ((occ == 3'd2) && pop_word));

    always_comb begin
        rd_data = pf_data[pf_rp][int'(sub) * RD_DATA_WIDTH +: RD_DATA_WIDTH];
    end

    always_comb begin
        free_banks = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (bank_st[i] == BANK_FREE) free_banks = free_banks + FW'(1);
        end
    end

    // The three transitions always target banks in distinct states, so they
    // never collide on the same bank.
    always_comb begin
        for (int i = 0; i < BANK_SLOTS; i++) bank_nxt[i] = bank_st[i];
        if (wr_fire) bank_nxt[wb] = (waddr == LAST_WORD) ? BANK_FULL : BANK_FILLING;
        if (issue && (raddr == '0)) bank_nxt[ib] = BANK_DRAINING;
        if (release_bank) bank_nxt[rb] = BANK_FREE;
    end

    rd_fram_pingpong_buf_sdpram #(
        .DATA_W (WR_DATA_WIDTH),
        .ADDR_W (BW + AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_fire),
        .waddr ({wb, waddr}),
        .wdata (wr_data),
        .re    (issue),
        .raddr ({ib, raddr}),
        .rdata (ram_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BANK_SLOTS; i++) bank_st[i] <= BANK_FREE;
            wb           <= '0;
            rb           <= '0;
            ib           <= '0;
            waddr        <= '0;
            raddr        <= '0;
            rd_pend      <= 1'b0;
            rd_pend_last <= 1'b0;
            pf_data[0]   <= '0;
            pf_data[1]   <= '0;
            pf_last[0]   <= 1'b0;
            pf_last[1]   <= 1'b0;
            pf_rp        <= 1'b0;
            pf_wp        <= 1'b0;
            pf_cnt       <= 2'd0;
            sub          <= '0;
            buf_req      <= 1'b0;
            ovf_err      <= 1'b0;
        end else if (frame_sync) begin
            for (int i = 0; i < BANK_SLOTS; i++) bank_st[i] <= BANK_FREE;
            wb           <= '0;
            rb           <= '0;
            ib           <= '0;
            waddr        <= '0;
            raddr        <= '0;
            rd_pend      <= 1'b0;
            rd_pend_last <= 1'b0;
            pf_data[0]   <= '0;
            pf_data[1]   <= '0;
            pf_last[0]   <= 1'b0;
            pf_last[1]   <= 1'b0;
            pf_rp        <= 1'b0;
            pf_wp        <= 1'b0;
            pf_cnt       <= 2'd0;
            sub          <= '0;
            buf_req      <= 1'b0;
            ovf_err      <= 1'b0;
        end else begin
            for (int i = 0; i < BANK_SLOTS; i++) bank_st[i] <= bank_nxt[i];

            if (wr_fire) begin
                waddr <= waddr + 1'b1;
                if (waddr == LAST_WORD) wb <= bank_inc(wb);
            end
            if (wr_en && !wr_ready) ovf_err <= 1'b1;

            if (issue) begin
                raddr <= raddr + 1'b1;
                if (raddr == LAST_WORD) ib <= bank_inc(ib);
            end
            rd_pend      <= issue;
            rd_pend_last <= issue && (raddr == LAST_WORD);

            if (rd_pend) begin
                pf_data[pf_wp] <= ram_rd_data;
                pf_last[pf_wp] <= rd_pend_last;
                pf_wp          <= ~pf_wp;
            end
            if (pop_word) pf_rp <= ~pf_rp;
            pf_cnt <= pf_cnt + 2'(rd_pend) - 2'(pop_word);

            if (rd_fire) sub <= (sub == LAST_SUB) ? '0 : sub + 1'b1;

            if (release_bank) rb <= bank_inc(rb);
            buf_req <= release_bank;
        end
    end

endmodule

// File: tb/tb_rd_fram_pingpong_buf.sv
module tb_rd_fram_pingpong_buf;

    localparam int LW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic         fs_a, we_a, wrdy_a, rv_a, rr_a, rl_a, breq_a, ovf_a;
    logic [127:0] wd_a;
    logic [31:0]  rdat_a;
    logic [1:0]   fb_a;

    logic         fs_b, we_b, wrdy_b, rv_b, rr_b, rl_b, breq_b, ovf_b;
    logic [31:0]  wd_b;
    logic [31:0]  rdat_b;
    logic [0:0]   fb_b;

    rd_fram_pingpong_buf #(
        .WR_DATA_WIDTH(128), .RD_DATA_WIDTH(32), .RATIO(4), .LINE_WORDS(LW), .NUM_BANKS(2)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .frame_sync(fs_a), .wr_data(wd_a), .wr_en(we_a),
        .wr_ready(wrdy_a), .rd_data(rdat_a), .rd_valid(rv_a), .rd_ready(rr_a),
        .rd_last(rl_a), .buf_req(breq_a), .free_banks(fb_a), .ovf_err(ovf_a)
    );

    rd_fram_pingpong_buf #(
        .WR_DATA_WIDTH(32), .RD_DATA_WIDTH(32), .RATIO(1), .LINE_WORDS(LW), .NUM_BANKS(1)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .frame_sync(fs_b), .wr_data(wd_b), .wr_en(we_b),
        .wr_ready(wrdy_b), .rd_data(rdat_b), .rd_valid(rv_b), .rd_ready(rr_b),
        .rd_last(rl_b), .buf_req(breq_b), .free_banks(fb_b), .ovf_err(ovf_b)
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Expected beats {last, data}
    logic [32:0] q_a[$];
    logic [32:0] q_b[$];
    int wcnt_a = 0;
    int wcnt_b = 0;
    int pops_a = 0;
    logic rnd_en = 1'b0;

    // ---------------- monitor A ----------------
    logic        prev_stall_a = 1'b0;
    logic        prev_rel_a   = 1'b0;
    logic [32:0] prev_out_a   = '0;
    logic [32:0] exp_a;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("buf_req_a", breq_a, prev_rel_a);
            if (prev_stall_a) chk("stall_hold_a", {rv_a, rl_a, rdat_a}, {1'b1, prev_out_a});
            if (rv_a && rr_a && !fs_a) begin
                if (q_a.size() == 0) begin
                    total++;
                    $display("FAIL beat_a: got unexpected beat 0x%0h expected none", rdat_a);
                end else begin
                    exp_a = q_a.pop_front();
                    chk("beat_a", {rl_a, rdat_a}, exp_a);
                end
                pops_a++;
            end
            prev_stall_a = rv_a && !rr_a && !fs_a;
            prev_rel_a   = rv_a && rr_a && rl_a && !fs_a;
            prev_out_a   = {rl_a, rdat_a};
        end
    end

    // ---------------- monitor B ----------------
    logic        prev_rel_b = 1'b0;
    logic [32:0] exp_b;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("buf_req_b", breq_b, prev_rel_b);
            if (rv_b && rr_b && !fs_b) begin
                if (q_b.size() == 0) begin
                    total++;
                    $display("FAIL beat_b: got unexpected beat 0x%0h expected none", rdat_b);
                end else begin
                    exp_b = q_b.pop_front();
                    chk("beat_b", {rl_b, rdat_b}, exp_b);
                end
            end
            prev_rel_b = rv_b && rr_b && rl_b && !fs_b;
        end
    end

    // random backpressure for DUT A
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_en) rr_a = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic write_a(input logic [127:0] d);
        int n = 0;
        while (!wrdy_a && n < 300) begin
            @(posedge clk); #1; n++;
        end
        if (!wrdy_a) begin
            total++;
            $display("FAIL wr_wait_a: got wr_ready 0 expected 1 within 300 cycles");
        end else begin
            we_a = 1'b1; wd_a = d;
            @(posedge clk); #1;
            we_a = 1'b0;
            for (int k = 0; k < 4; k++)
                q_a.push_back({(wcnt_a == LW - 1) && (k == 3), d[k*32 +: 32]});
            wcnt_a = (wcnt_a + 1) % LW;
        end
    endtask

    task automatic write_line_a(input int base);
        logic [127:0] d;
        for (int w = 0; w < LW; w++) begin
            for (int k = 0; k < 4; k++) d[k*32 +: 32] = 32'(base + 4*w + k);
            write_a(d);
        end
    endtask

    task automatic write_b(input logic [31:0] d);
        int n = 0;
        while (!wrdy_b && n < 300) begin
            @(posedge clk); #1; n++;
        end
        if (!wrdy_b) begin
            total++;
            $display("FAIL wr_wait_b: got wr_ready 0 expected 1 within 300 cycles");
        end else begin
            we_b = 1'b1; wd_b = d;
            @(posedge clk); #1;
            we_b = 1'b0;
            q_b.push_back({wcnt_b == LW - 1, d});
            wcnt_b = (wcnt_b + 1) % LW;
        end
    endtask

    task automatic drain_a();
        int n = 0;
        while (q_a.size() != 0 && n < 3000) begin
            @(negedge clk); n++;
        end
        if (q_a.size() != 0) begin
            total++;
            $display("FAIL drain_a: got %0d beats outstanding expected 0", q_a.size());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic drain_b();
        int n = 0;
        while (q_b.size() != 0 && n < 3000) begin
            @(negedge clk); n++;
        end
        if (q_b.size() != 0) begin
            total++;
            $display("FAIL drain_b: got %0d beats outstanding expected 0", q_b.size());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic gap_check_a(input int beats);
        int n = 0;
        while (!rv_a && n < 100) begin
            @(negedge clk); n++;
        end
        for (int i = 0; i < beats; i++) begin
            chk("no_gap_a", rv_a, 1'b1);
            @(negedge clk);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        rst_n = 1'b0;
        fs_a = 0; we_a = 0; wd_a = '0; rr_a = 1'b1;
        fs_b = 0; we_b = 0; wd_b = '0; rr_b = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);

        // reset state
        chk("rst_rd_valid_a", rv_a, 1'b0);
        chk("rst_rd_data_a", rdat_a, 32'h0);
        chk("rst_rd_last_a", rl_a, 1'b0);
        chk("rst_wr_ready_a", wrdy_a, 1'b1);
        chk("rst_free_banks_a", fb_a, 2'd2);
        chk("rst_ovf_a", ovf_a, 1'b0);
        chk("rst_wr_ready_b", wrdy_b, 1'b1);
        chk("rst_free_banks_b", fb_b, 1'b1);
        chk("rst_rd_valid_b", rv_b, 1'b0);

        // 1: single line, beats 0..15, rd_last on 16th
        write_line_a(0);
        chk("free_banks_after_fill1", fb_a, 2'd1);
        drain_a();
        chk("free_banks_after_drain1", fb_a, 2'd2);

        // 2: two lines back-to-back, 32 contiguous beats
        fork
            begin write_line_a(100); write_line_a(200); end
            gap_check_a(32);
        join
        drain_a();

        // 3: random backpressure over three lines
        rnd_en = 1'b1;
        write_line_a(300);
        write_line_a(400);
        write_line_a(500);
        drain_a();
        rnd_en = 1'b0;
        rr_a = 1'b1;
        @(negedge clk);

        // 4: all banks full, write dropped, sticky overflow
        rr_a = 1'b0;
        write_line_a(600);
        write_line_a(700);
        chk("full_wr_ready_a", wrdy_a, 1'b0);
        chk("full_free_banks_a", fb_a, 2'd0);
        we_a = 1'b1; wd_a = {4{32'hDEAD_BEEF}};
        @(posedge clk); #1;
        we_a = 1'b0;
        chk("ovf_set_a", ovf_a, 1'b1);
        rr_a = 1'b1;
        drain_a();
        chk("ovf_sticky_a", ovf_a, 1'b1);
        chk("drained_free_banks_a", fb_a, 2'd2);

        // 5: frame_sync mid-drain of bank 1
        n = pops_a;
        write_line_a(800);
        write_line_a(900);
        begin
            int t = 0;
            while (pops_a < n + 20 && t < 200) begin
                @(posedge clk); #1; t++;
            end
        end
        chk("fs_reached_bank1", (pops_a >= n + 20), 1'b1);
        fs_a = 1'b1;
        q_a.delete();
        wcnt_a = 0;
        @(posedge clk); #1;
        fs_a = 1'b0;
        @(negedge clk);
        chk("fs_rd_valid_a", rv_a, 1'b0);
        chk("fs_rd_data_a", rdat_a, 32'h0);
        chk("fs_free_banks_a", fb_a, 2'd2);
        chk("fs_ovf_a", ovf_a, 1'b0);
        chk("fs_wr_ready_a", wrdy_a, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("fs_no_stale_a", rv_a, 1'b0);
        end
        write_line_a(1000);
        drain_a();

        // 6: RATIO=1, single bank
        for (int w = 0; w < LW; w++) write_b(32'hB0 + 32'(w));
        chk("b_full_wr_ready", wrdy_b, 1'b0);
        chk("b_full_free_banks", fb_b, 1'b0);
        @(negedge clk);
        begin
            int t = 0;
            while (!rv_b && t < 20) begin
                @(negedge clk); t++;
            end
            for (int i = 0; i < LW; i++) begin
                chk("b_no_gap", rv_b, 1'b1);
                if (i < LW - 1) @(negedge clk);
            end
            chk("b_last_beat", rl_b, 1'b1);
        end
        @(posedge clk); #1;
        chk("b_refill_ready", wrdy_b, 1'b1);
        chk("b_refill_free_banks", fb_b, 1'b1);
        for (int w = 0; w < LW; w++) write_b(32'hC0 + 32'(w));
        drain_b();

        chk("q_a_empty", q_a.size(), 0);
        chk("q_b_empty", q_b.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
